// File: rtl/ccp_pt_feeder.sv
// ccp_pt_feeder
//
// Plaintext block feeder for ccp_aead. Takes a 32-bit word stream from the
// host/DMA side, packs it into 512-bit ChaCha20 blocks (zero padding past the
// message length) and keeps up to two finished blocks in a ping-pong buffer.
// Each rising edge on i_rqst_pt is answered with a one-cycle o_en_pt strobe
// and the oldest finished block on o_pt.
//
// Optional feature: define CCP_FEEDER_TIMEOUT_EN to enable the request
// starvation timer that drives o_err. When it is undefined o_err is tied low.
//
// Ports
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_start, i_len_pt  start pulse; latches the message length in bytes
//   i_valid, i_data    upstream word stream, i_data[7:0] is the earliest byte
//   o_ready            feeder takes a word this cycle
//   i_rqst_pt          block request from ccp_aead, rising-edge sensitive
//   o_en_pt, o_pt      one-cycle strobe with the block (held between strobes)
//   o_done             one-cycle pulse after the final block was issued
//   o_err              sticky starvation error
//   o_state            current FSM state (debug visibility)
//
// Handshake: a word transfers on a rising clock edge where i_valid and
// o_ready are both 1. o_ready depends on registered state only, so it never
// combinationally follows i_valid or i_rqst_pt; upstream may hold i_valid
// high with stable data until the transfer happens.

module ccp_pt_feeder #(
  parameter int CC_D_WIDTH = 512,
  parameter int TO_CYCLES  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [31:0]           i_len_pt,
  input  logic                  i_valid,
  input  logic [31:0]           i_data,
  output logic                  o_ready,
  input  logic                  i_rqst_pt,
  output logic                  o_en_pt,
  output logic [CC_D_WIDTH-1:0] o_pt,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state;
  logic [31:0]           len_q;
  logic [31:0]           acc;
  logic [3:0]            wcnt;
  logic                  wr;
  logic                  rd;
  logic [1:0]            cnt_blk;
  logic [26:0]           issued;
  logic                  rqst_d;
  logic                  pend;
  logic [CC_D_WIDTH-1:0] slot [2];

  logic                  run;
  logic [26:0]           nblk;
  logic [32:0]           acc_nxt;
  logic                  accept;
  logic                  slot_cmp;
  logic                  rq_edge;
  logic                  serve;
  logic [31:0]           word_m;
  logic [CC_D_WIDTH-1:0] slot_nxt;

  assign run     = (state == ST_RUN);
  // Number of blocks in the message: ceil(len / 64).
  assign nblk    = {1'b0, len_q[31:6]} + 27'(|len_q[5:0]);
  assign acc_nxt = {1'b0, acc} + 33'd4;

  assign o_ready  = run && (cnt_blk < 2'd2) && (acc < len_q);
  assign accept   = i_valid && o_ready && !i_start;
  assign slot_cmp = accept && ((wcnt == 4'd15) || (acc_nxt >= {1'b0, len_q}));

  // A request edge is usable in the same cycle it is seen, so a buffered
  // block goes out on the very next cycle without waiting for pend.
  assign rq_edge = i_rqst_pt && !rqst_d;
  assign serve   = run && !i_start && (pend || rq_edge) && (cnt_blk != 2'd0);

  assign o_done  = (state == ST_DONE);
  assign o_state = state;

  // Bytes at or beyond the message length are forced to zero.
  always_comb begin
    word_m = '0;
    for (int j = 0; j < 4; j++) begin
      if (({1'b0, acc} + 33'(j)) < {1'b0, len_q}) begin
        word_m[8*j +: 8] = i_data[8*j +: 8];
      end
    end
  end

  // Opening a slot (first word) starts from zero, which also provides the
  // zero words above the last written one of a short final block.
  always_comb begin
    slot_nxt = (wcnt == 4'd0) ? '0 : slot[wr];
    slot_nxt[{wcnt, 5'd0} +: 32] = word_m;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      acc     <= '0;
      wcnt    <= '0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      cnt_blk <= '0;
      issued  <= '0;
      rqst_d  <= 1'b0;
      pend    <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
      o_en_pt <= 1'b0;
      o_pt    <= '0;
    end else begin
      rqst_d <= i_rqst_pt;
      if (i_start) begin
        state   <= ST_RUN;
        len_q   <= i_len_pt;
        acc     <= '0;
        wcnt    <= '0;
        wr      <= 1'b0;
        rd      <= 1'b0;
        cnt_blk <= '0;
        issued  <= '0;
        pend    <= 1'b0;
        slot[0] <= '0;
        slot[1] <= '0;
        o_en_pt <= 1'b0;
      end else begin
        o_en_pt <= serve;

        if (serve) begin
          o_pt   <= slot[rd];
          rd     <= ~rd;
          issued <= issued + 27'd1;
        end

        // Edges outside RUN are dropped; a second edge while pending is a no-op.
        if (serve)                pend <= 1'b0;
        else if (run && rq_edge)  pend <= 1'b1;
        else if (!run)            pend <= 1'b0;

        if (accept) begin
          slot[wr] <= slot_nxt;
          acc      <= acc_nxt[31:0];
          if (slot_cmp) begin
            wcnt <= '0;
            wr   <= ~wr;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end

        case ({slot_cmp, serve})
          2'b10:   cnt_blk <= cnt_blk + 2'd1;
          2'b01:   cnt_blk <= cnt_blk - 2'd1;
          default: cnt_blk <= cnt_blk;
        endcase

        case (state)
          ST_IDLE: state <= ST_IDLE;
          // issued already counts the block on the current strobe, so DONE
          // lands one cycle after the final strobe (or right away for len 0).
          ST_RUN:  if (issued == nblk) state <= ST_DONE;
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CCP_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counts cycles in which a request waits with nothing buffered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt <= '0;
      o_err  <= 1'b0;
    end else if (i_start) begin
      to_cnt <= '0;
      o_err  <= 1'b0;
    end else if (run && pend && (cnt_blk == 2'd0)) begin
      if (to_cnt != TW'(TO_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TW'(TO_CYCLES - 1)) o_err <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  // Timer absent: o_err is constant low whatever TO_CYCLES is set to.
  assign o_err = (TO_CYCLES < 1) ? 1'b0 : 1'b0;
`endif

endmodule
